bongo_responder: RTL and testbench



---
 rtl/bongo_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_bongo_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bongo_responder.sv
`default_nettype none
// ============================================================================
// Module      : bongo_responder
// Description : Joybus device endpoint that answers identify and poll commands
//               as a DK Bongos controller on an open-drain data line.
// Revision    : 1.0 - initial release
// ============================================================================
module bongo_responder #(
    parameter int          CLK_FREQ  = 50000000,
    parameter logic [23:0] DEVICE_ID = 24'h090000,
    parameter int          IDLE_US   = 5
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         dataPort,
    input  logic [63:0] report,
    output logic        poll_strobe,
    output logic        rumble,
    output logic        busy,
    output logic        cmd_error
);

    localparam int c_US       = CLK_FREQ / 1000000;
    localparam int c_CNT_SPAN = (8 * c_US > IDLE_US * c_US) ? 8 * c_US : IDLE_US * c_US;
    localparam int c_CNT_W    = $clog2(c_CNT_SPAN + 2);

    // Counter end values are "last count" values: a phase of N cycles ends at N-1.
    localparam logic [c_CNT_W-1:0] c_ONE_LOW    = c_CNT_W'(c_US - 1);
    localparam logic [c_CNT_W-1:0] c_ZERO_LOW   = c_CNT_W'(3 * c_US - 1);
    localparam logic [c_CNT_W-1:0] c_ONE_HIGH   = c_CNT_W'(3 * c_US - 1);
    localparam logic [c_CNT_W-1:0] c_ZERO_HIGH  = c_CNT_W'(c_US - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_END   = c_CNT_W'(2 * c_US - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_THRESH = c_CNT_W'(2 * c_US - 1);
    localparam logic [c_CNT_W-1:0] c_LONG_LOW   = c_CNT_W'(8 * c_US);
    localparam logic [c_CNT_W-1:0] c_IDLE_END   = c_CNT_W'(IDLE_US * c_US - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT    = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_LOW  = 3'd1,
        RX_HIGH = 3'd2,
        DECODE  = 3'd3,
        TX_LOW  = 3'd4,
        TX_HIGH = 3'd5,
        TX_STOP = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_syncPrev;
    logic               w_fall;
    logic               w_rise;

    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_bitCnt;
    logic [24:0]        r_rxShift;
    logic               r_rxErr;

    logic [63:0]        r_txShift;
    logic [6:0]         r_txLeft;
    logic               r_driveLow;

    logic               r_pollStrobe;
    logic               r_cmdError;
    logic               r_rumble;

    logic               w_txBit;
    logic               w_lowEnd;
    logic               w_highEnd;
    logic               w_isIdentify;
    logic               w_isPoll;
    logic               w_unusedModeByte;

    assign dataPort    = r_driveLow ? 1'b0 : 1'bz;
    assign poll_strobe = r_pollStrobe;
    assign cmd_error   = r_cmdError;
    assign rumble      = r_rumble;
    assign busy        = (r_state != IDLE);

    // The line idles high, so the synchroniser resets high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_syncPrev <= 1'b1;
        end else begin
            r_sync1    <= dataPort;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
        end
    end

    assign w_fall = r_syncPrev & ~r_sync2;
    assign w_rise = ~r_syncPrev & r_sync2;

    assign w_txBit   = r_txShift[63];
    assign w_lowEnd  = (r_cnt == (w_txBit ? c_ONE_LOW : c_ZERO_LOW));
    assign w_highEnd = (r_cnt == (w_txBit ? c_ONE_HIGH : c_ZERO_HIGH));

    // Frames carry a trailing console stop bit, which decodes as a final '1'.
    assign w_isIdentify = !r_rxErr && (r_bitCnt == 5'd9) && r_rxShift[0] &&
                          ((r_rxShift[8:1] == 8'h00) || (r_rxShift[8:1] == 8'hFF));
    assign w_isPoll     = !r_rxErr && (r_bitCnt == 5'd25) && r_rxShift[0] &&
                          (r_rxShift[24:17] == 8'h40);
    assign w_unusedModeByte = ^r_rxShift[16:9];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_stateNext = RX_LOW;
                end
            end
            RX_LOW: begin
                if (w_rise) begin
                    w_stateNext = RX_HIGH;
                end
            end
            RX_HIGH: begin
                if (w_fall) begin
                    w_stateNext = RX_LOW;
                end else if (r_cnt == c_IDLE_END) begin
                    w_stateNext = DECODE;
                end
            end
            DECODE: begin
                w_stateNext = (w_isIdentify || w_isPoll) ? TX_LOW : IDLE;
            end
            TX_LOW: begin
                if (w_lowEnd) begin
                    w_stateNext = TX_HIGH;
                end
            end
            TX_HIGH: begin
                if (w_highEnd) begin
                    w_stateNext = (r_txLeft == 7'd1) ? TX_STOP : TX_LOW;
                end
            end
            TX_STOP: begin
                if (r_cnt == c_STOP_END) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Phase counter restarts on every state change and saturates otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_stateNext != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt     <= '0;
            r_rxShift    <= '0;
            r_rxErr      <= 1'b0;
            r_txShift    <= '0;
            r_txLeft     <= '0;
            r_driveLow   <= 1'b0;
            r_pollStrobe <= 1'b0;
            r_cmdError   <= 1'b0;
            r_rumble     <= 1'b0;
        end else begin
            r_pollStrobe <= 1'b0;
            r_cmdError   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_bitCnt  <= '0;
                        r_rxShift <= '0;
                        r_rxErr   <= 1'b0;
                    end
                end
                RX_LOW: begin
                    // r_cnt holds the low width minus one when the rise is seen.
                    if (w_rise) begin
                        r_rxShift <= {r_rxShift[23:0], (r_cnt < c_BIT_THRESH)};
                        if (r_bitCnt != 5'd31) begin
                            r_bitCnt <= r_bitCnt + 5'd1;
                        end
                    end else if (r_cnt >= c_LONG_LOW) begin
                        r_rxErr <= 1'b1;
                    end
                end
                DECODE: begin
                    if (w_isPoll) begin
                        r_txShift    <= report;
                        r_txLeft     <= 7'd64;
                        r_pollStrobe <= 1'b1;
                        r_rumble     <= r_rxShift[1];
                    end else if (w_isIdentify) begin
                        r_txShift <= {DEVICE_ID, 40'h0};
                        r_txLeft  <= 7'd24;
                    end else begin
                        r_cmdError <= 1'b1;
                    end
                end
                TX_HIGH: begin
                    if (w_highEnd) begin
                        r_txShift <= {r_txShift[62:0], 1'b0};
                        r_txLeft  <= r_txLeft - 7'd1;
                    end
                end
                default: begin
                end
            endcase
            r_driveLow <= (w_stateNext == TX_LOW) || (w_stateNext == TX_STOP);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bongo_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bongo_responder
// Description : Console-side stimulus and reply scoreboard for bongo_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bongo_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] report = '0;
    logic        poll_strobe;
    logic        rumble;
    logic        busy;
    logic        cmd_error;
    logic        consoleLow = 1'b0;
    wire         dataLine;

    pullup (dataLine);
    assign dataLine = consoleLow ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    bongo_responder #(
        .CLK_FREQ  (50000000),
        .DEVICE_ID (24'h090000),
        .IDLE_US   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dataPort    (dataLine),
        .report      (report),
        .poll_strobe (poll_strobe),
        .rumble      (rumble),
        .busy        (busy),
        .cmd_error   (cmd_error)
    );

    typedef struct {
        logic [63:0] val;
        int          len;
    } reply_t;

    typedef struct {
        logic [39:0] frame;
        int          frameLen;
        int          lowOne;
        logic [63:0] rep;
        bit          expReply;
        logic [63:0] replyVal;
        int          replyLen;
        int          expStrobe;
        int          expErr;
        logic        expRumble;
    } vec_t;

    reply_t      expQ[$];
    int          nCmp = 0;
    int          nFail = 0;
    int          cyc = 0;
    int          lowRun = 0;
    int          monBits = 0;
    int          startCyc = 0;
    int          riseCyc = 0;
    int          strobeCnt = 0;
    int          errCnt = 0;
    bit          inReply = 1'b0;
    logic [63:0] acc = '0;

    localparam logic [39:0] c_POLL_R1 = 40'({8'h40, 8'h03, 8'h01, 1'b1});
    localparam logic [39:0] c_POLL_R0 = 40'({8'h40, 8'h03, 8'h00, 1'b1});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reply monitor: measures DUT-driven low widths on the falling clock edge.
    initial begin
        reply_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                lowRun  = 0;
                monBits = 0;
                acc     = '0;
                inReply = 1'b0;
                expQ.delete();
            end else begin
                strobeCnt += int'(poll_strobe);
                errCnt    += int'(cmd_error);
                if (!consoleLow && dataLine === 1'b0) begin
                    if (lowRun == 0 && !inReply) begin
                        inReply  = 1'b1;
                        startCyc = cyc;
                        acc      = '0;
                        monBits  = 0;
                    end
                    lowRun++;
                end else if (lowRun != 0) begin
                    if (lowRun == 50) begin
                        acc = {acc[62:0], 1'b1};
                        monBits++;
                    end else if (lowRun == 150) begin
                        acc = {acc[62:0], 1'b0};
                        monBits++;
                    end else if (lowRun == 100) begin
                        if (expQ.size() == 0) begin
                            nCmp++;
                            nFail++;
                            $display("FAIL unexpected_reply: got %0d bits %h, required none", monBits, acc);
                        end else begin
                            e = expQ.pop_front();
                            check("reply_len", 64'(monBits), 64'(e.len));
                            check("reply_data", acc, e.val);
                            check("reply_duration", 64'(cyc - startCyc), 64'(e.len * 200 + 100));
                            nCmp++;
                            if ((startCyc - riseCyc) < 245 || (startCyc - riseCyc) > 265) begin
                                nFail++;
                                $display("FAIL turnaround: got %0d cycles, required 245..265", startCyc - riseCyc);
                            end
                        end
                        inReply = 1'b0;
                    end else begin
                        nCmp++;
                        nFail++;
                        $display("FAIL low_width: got %0d cycles, required 50, 100 or 150", lowRun);
                    end
                    lowRun = 0;
                end
            end
        end
    end

    task automatic sendFrame(input logic [39:0] bits, input int len, input int lowOne);
        int lowW;
        @(posedge clk);
        #1;
        for (int i = len - 1; i >= 0; i--) begin
            lowW = bits[i] ? lowOne : 150;
            consoleLow = 1'b1;
            repeat (lowW) @(posedge clk);
            #1;
            consoleLow = 1'b0;
            if (i != 0) begin
                repeat (200 - lowW) @(posedge clk);
                #1;
            end
        end
        riseCyc = cyc;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic runEntry(input vec_t v);
        int s0;
        int e0;
        report = v.rep;
        s0 = strobeCnt;
        e0 = errCnt;
        if (v.expReply) begin
            expQ.push_back('{v.replyVal, v.replyLen});
        end
        sendFrame(v.frame, v.frameLen, v.lowOne);
        waitIdle("busy_release");
        check("strobe_count", 64'(strobeCnt - s0), 64'(v.expStrobe));
        check("error_count", 64'(errCnt - e0), 64'(v.expErr));
        check("rumble", 64'(rumble), 64'(v.expRumble));
        check("reply_pending", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #(200000 * 20);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        vec_t idv;
        int   n;

        vecs[0] = '{40'h001, 9, 50, 64'h0, 1'b1, 64'h090000, 24, 0, 0, 1'b0};
        vecs[1] = '{c_POLL_R1, 25, 50, 64'h0080_8080_8080_4000, 1'b1,
                    64'h0080_8080_8080_4000, 64, 1, 0, 1'b1};
        vecs[2] = '{40'h1FF, 9, 50, 64'h0, 1'b1, 64'h090000, 24, 0, 0, 1'b1};
        vecs[3] = '{40'h083, 9, 50, 64'h0, 1'b0, 64'h0, 0, 0, 1, 1'b1};
        vecs[4] = '{40'({8'h40, 8'h03, 8'h00, 8'h00, 1'b1}), 33, 50, 64'h0, 1'b0,
                    64'h0, 0, 0, 1, 1'b1};
        vecs[5] = '{c_POLL_R0, 25, 50, 64'h1234_5678_9ABC_DEF0, 1'b1,
                    64'h1234_5678_9ABC_DEF0, 64, 1, 0, 1'b0};
        vecs[6] = '{40'h1FF, 9, 90, 64'h0, 1'b1, 64'h090000, 24, 0, 0, 1'b0};
        vecs[7] = '{40'h1FF, 9, 110, 64'h0, 1'b0, 64'h0, 0, 0, 1, 1'b0};
        vecs[8] = '{40'h1FF, 9, 100, 64'h0, 1'b0, 64'h0, 0, 0, 1, 1'b0};
        vecs[9] = '{40'h000, 8, 50, 64'h0, 1'b0, 64'h0, 0, 0, 1, 1'b0};

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_line", 64'(dataLine), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_strobe", 64'(poll_strobe), 64'd0);
        check("reset_rumble", 64'(rumble), 64'd0);
        check("reset_cmd_error", 64'(cmd_error), 64'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            runEntry(vecs[i]);
        end

        // Report changes after the latch must not reach the in-flight reply.
        report = 64'hCAFE_F00D_0123_4567;
        expQ.push_back('{64'hCAFE_F00D_0123_4567, 64});
        sendFrame(c_POLL_R1, 25, 50);
        n = 0;
        while (poll_strobe !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latch_strobe_seen", 64'(poll_strobe), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        report = 64'h0F0F_0F0F_F0F0_F0F0;
        waitIdle("latch_busy_release");
        check("latch_reply_pending", 64'(expQ.size()), 64'd0);

        // Reset while bit 20 of a poll reply is being driven low.
        report = 64'hA5A5_0F0F_3C3C_9669;
        expQ.push_back('{64'hA5A5_0F0F_3C3C_9669, 64});
        sendFrame(c_POLL_R1, 25, 50);
        n = 0;
        while (!(inReply && monBits == 20 && dataLine === 1'b0) && n < 30000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midreply_line_low", 64'(dataLine), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreply_line_released", 64'(dataLine), 64'd1);
        check("midreply_busy", 64'(busy), 64'd0);
        check("midreply_rumble", 64'(rumble), 64'd0);
        check("midreply_strobe", 64'(poll_strobe), 64'd0);
        check("midreply_cmd_error", 64'(cmd_error), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        idv = vecs[0];
        runEntry(idv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
